// File: rtl/exec_sequencer_if.sv
// Host command port of the run-control sequencer.
// Latency: none, plain wires bundling one valid/ready channel.
// Backpressure: Cmd_ready from the sequencer; a command transfers on a rising edge with Cmd_valid && Cmd_ready.
//
// Signals:
//   Cmd_valid  host -> seq  command present
//   Cmd_ready  seq -> host  command can be taken this cycle
//   Cmd_op     host -> seq  00 RUN, 01 HALT, 10 STEP, 11 SET_BP
//   Cmd_data   host -> seq  SET_BP payload: [31:2] breakpoint word address, [0] enable
interface exec_sequencer_if;
  logic        Cmd_valid;
  logic        Cmd_ready;
  logic [1:0]  Cmd_op;
  logic [31:0] Cmd_data;

  modport master (
    output Cmd_valid,
    output Cmd_op,
    output Cmd_data,
    input  Cmd_ready
  );

  modport slave (
    input  Cmd_valid,
    input  Cmd_op,
    input  Cmd_data,
    output Cmd_ready
  );
endinterface

// File: rtl/exec_sequencer.sv
// Run-control sequencer gating every architectural update of the RV32I core through Core_en.
// Latency: commands take effect on the accepting edge; breakpoint/EBREAK halts drop Core_en in the same cycle.
// Backpressure: Cmd_ready is low only during the single STEP cycle; Core_en has no path from the command port.
//
// Ports:
//   Clk, Rst_n    clock, asynchronous active-low reset
//   cmd           command port (exec_sequencer_if.slave)
//   Pc            current PC of the core
//   Instruction   instruction fetched at Pc
//   Core_en       1 = core commits the instruction at Pc this cycle
//   State         00 HALTED, 01 RUNNING, 10 STEP
//   Halted        State == HALTED
//   Halt_cause    00 reset, 01 HALT command, 10 breakpoint, 11 EBREAK
//   Cycle_count   cycles spent outside HALTED (wraps)
//   Instr_count   cycles with Core_en = 1 (wraps)
module exec_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic               Clk,
  input  logic               Rst_n,
  exec_sequencer_if.slave    cmd,
  input  logic [31:0]        Pc,
  input  logic [31:0]        Instruction,
  output logic               Core_en,
  output logic [1:0]         State,
  output logic               Halted,
  output logic [1:0]         Halt_cause,
  output logic [CNT_W-1:0]   Cycle_count,
  output logic [CNT_W-1:0]   Instr_count
);

  localparam logic [1:0] ST_HALTED  = 2'b00;
  localparam logic [1:0] ST_RUNNING = 2'b01;
  localparam logic [1:0] ST_STEP    = 2'b10;

  localparam logic [1:0] OP_RUN    = 2'b00;
  localparam logic [1:0] OP_HALT   = 2'b01;
  localparam logic [1:0] OP_STEP   = 2'b10;
  localparam logic [1:0] OP_SET_BP = 2'b11;

  localparam logic [1:0] CAUSE_RESET = 2'b00;
  localparam logic [1:0] CAUSE_HALT  = 2'b01;
  localparam logic [1:0] CAUSE_BP    = 2'b10;
  localparam logic [1:0] CAUSE_EBRK  = 2'b11;

  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

  logic [1:0]  stateQ, stateD;
  logic [1:0]  causeQ, causeD;
  logic        skipQ, skipD;
  logic [29:0] bpAddrQ;
  logic        bpEnQ;

  logic        cmdReady;
  logic        cmdAcc;
  logic        bpHit;
  logic        ebrk;
  logic        coreEn;

  // Byte-offset bits of Pc and the spare payload bit carry no meaning here.
  logic        unusedBits;
  assign unusedBits = ^{Pc[1:0], cmd.Cmd_data[1]};

  assign cmdAcc = cmd.Cmd_valid && cmdReady;

  // Skip masks the breakpoint at the PC we resumed from, so RUN from a
  // breakpoint address makes progress instead of re-halting immediately.
  assign bpHit = bpEnQ && (Pc[31:2] == bpAddrQ) && !skipQ;
  assign ebrk  = (Instruction == EBREAK_INSN);

  //--------------------------------------------------------------------------
  // State register
  //--------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stateQ <= ST_HALTED;
      causeQ <= CAUSE_RESET;
      skipQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      causeQ <= causeD;
      skipQ  <= skipD;
    end
  end

  //--------------------------------------------------------------------------
  // Next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    stateD = stateQ;
    causeD = causeQ;
    skipD  = skipQ;
    unique case (stateQ)
      ST_HALTED: begin
        // HALT and SET_BP leave the state (and the last cause) alone.
        if (cmdAcc && cmd.Cmd_op == OP_RUN) begin
          stateD = ST_RUNNING;
          skipD  = 1'b1;
        end else if (cmdAcc && cmd.Cmd_op == OP_STEP) begin
          stateD = ST_STEP;
        end
      end
      ST_RUNNING: begin
        skipD = 1'b0;
        // EBREAK outranks the breakpoint, which outranks a host HALT.
        if (ebrk) begin
          stateD = ST_HALTED;
          causeD = CAUSE_EBRK;
        end else if (bpHit) begin
          stateD = ST_HALTED;
          causeD = CAUSE_BP;
        end else if (cmdAcc && cmd.Cmd_op == OP_HALT) begin
          stateD = ST_HALTED;
          causeD = CAUSE_HALT;
        end
      end
      ST_STEP: begin
        stateD = ST_HALTED;
        causeD = ebrk ? CAUSE_EBRK : CAUSE_HALT;
      end
      default: begin
        // Unused encoding: fall back to a safe halted core.
        stateD = ST_HALTED;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Output logic (pure function of registered state and core-side inputs)
  //--------------------------------------------------------------------------
  always_comb begin
    coreEn   = 1'b0;
    cmdReady = 1'b1;
    unique case (stateQ)
      ST_RUNNING: coreEn = !(bpHit || ebrk);
      ST_STEP: begin
        coreEn   = !ebrk;     // breakpoint deliberately ignored while stepping
        cmdReady = 1'b0;
      end
      default: coreEn = 1'b0;
    endcase
  end

  assign Core_en       = coreEn;
  assign cmd.Cmd_ready = cmdReady;
  assign State         = stateQ;
  assign Halted        = (stateQ == ST_HALTED);
  assign Halt_cause    = causeQ;

  //--------------------------------------------------------------------------
  // Breakpoint register
  //--------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      bpAddrQ <= '0;
      bpEnQ   <= 1'b0;
    end else if (cmdAcc && cmd.Cmd_op == OP_SET_BP) begin
      bpAddrQ <= cmd.Cmd_data[31:2];
      bpEnQ   <= cmd.Cmd_data[0];
    end
  end

  //--------------------------------------------------------------------------
  // Counters: sample pre-edge state and Core_en, wrap freely
  //--------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Cycle_count <= '0;
      Instr_count <= '0;
    end else begin
      if (stateQ != ST_HALTED) Cycle_count <= Cycle_count + CNT_W'(1);
      if (coreEn)              Instr_count <= Instr_count + CNT_W'(1);
    end
  end

  //--------------------------------------------------------------------------
  // Run-control invariants
  //--------------------------------------------------------------------------
  assert property (@(posedge Clk) disable iff (!Rst_n) (stateQ == ST_HALTED) |-> !coreEn);
  assert property (@(posedge Clk) disable iff (!Rst_n) (stateQ == ST_STEP) |=> (stateQ == ST_HALTED));
  assert property (@(posedge Clk) disable iff (!Rst_n) (stateQ != 2'b11));

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: directed run-control scenarios followed by random commands.
// Two instances (CNT_W = 32 and CNT_W = 4) see identical stimulus; the narrow one exercises counter wrap.
module tb_exec_sequencer;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ADDI   = 32'h0010_0093;
  localparam logic [1:0]  OP_RUN = 2'd0, OP_HALT = 2'd1, OP_STEP = 2'd2, OP_SETBP = 2'd3;
  localparam logic [1:0]  S_HALT = 2'd0, S_RUN = 2'd1, S_STEP = 2'd2;

  typedef struct {
    logic        coreEn;
    logic [1:0]  state;
    logic        halted;
    logic [1:0]  cause;
    logic        rdy;
    logic [31:0] cyc;
    logic [31:0] ins;
  } exp_t;

  logic        Clk;
  logic        Rst_n = 1'b0;
  logic [31:0] Pc = '0;
  logic [31:0] Instruction = ADDI;

  logic        Core_en, coreEnW;
  logic [1:0]  State, stateW, Halt_cause, causeW;
  logic        Halted, haltedW;
  logic [31:0] Cycle_count, Instr_count;
  logic [3:0]  cycW, insW;

  exec_sequencer_if cmdIf();
  exec_sequencer_if cmdIfW();
  assign cmdIfW.Cmd_valid = cmdIf.Cmd_valid;
  assign cmdIfW.Cmd_op    = cmdIf.Cmd_op;
  assign cmdIfW.Cmd_data  = cmdIf.Cmd_data;

  exec_sequencer #(.CNT_W(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .cmd(cmdIf), .Pc(Pc), .Instruction(Instruction),
    .Core_en(Core_en), .State(State), .Halted(Halted), .Halt_cause(Halt_cause),
    .Cycle_count(Cycle_count), .Instr_count(Instr_count)
  );

  exec_sequencer #(.CNT_W(4)) dutW (
    .Clk(Clk), .Rst_n(Rst_n), .cmd(cmdIfW), .Pc(Pc), .Instruction(Instruction),
    .Core_en(coreEnW), .State(stateW), .Halted(haltedW), .Halt_cause(causeW),
    .Cycle_count(cycW), .Instr_count(insW)
  );

  initial begin
    Clk = 1'b1;
    forever #5 Clk = ~Clk;
  end

  // Reference model state
  logic [1:0]  mState;
  logic [1:0]  mCause;
  bit          mSkip, mBpEn;
  logic [29:0] mBpAddr;
  logic [31:0] mCyc, mIns;
  logic [31:0] pc, ebrkPc;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, req);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  always @(negedge Clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      chk("core_en",   32'(Core_en),          32'(e.coreEn));
      chk("state",     32'(State),            32'(e.state));
      chk("halted",    32'(Halted),           32'(e.halted));
      chk("cause",     32'(Halt_cause),       32'(e.cause));
      chk("cmd_ready", 32'(cmdIf.Cmd_ready),  32'(e.rdy));
      chk("cycles",    Cycle_count,           e.cyc);
      chk("instrs",    Instr_count,           e.ins);
      chk("w_core_en", 32'(coreEnW),          32'(e.coreEn));
      chk("w_state",   32'(stateW),           32'(e.state));
      chk("w_cause",   32'(causeW),           32'(e.cause));
      chk("w_ready",   32'(cmdIfW.Cmd_ready), 32'(e.rdy));
      chk("w_cycles",  32'(cycW),             32'(e.cyc[3:0]));
      chk("w_instrs",  32'(insW),             32'(e.ins[3:0]));
    end
  end

  task automatic modelReset();
    mState = S_HALT; mCause = 2'd0; mSkip = 1'b0; mBpEn = 1'b0;
    mBpAddr = '0; mCyc = '0; mIns = '0;
  endtask

  // Assert reset mid-cycle, expect reset values immediately, release after the next edge.
  task automatic doReset();
    exp_t e;
    cmdIf.Cmd_valid = 1'b0;
    #2;
    Rst_n = 1'b0;
    modelReset();
    e.coreEn = 1'b0; e.state = S_HALT; e.halted = 1'b1; e.cause = 2'd0;
    e.rdy = 1'b1; e.cyc = '0; e.ins = '0;
    expQ.push_back(e);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
  endtask

  // One core cycle: present inputs, predict outputs, then apply the rules at the edge.
  task automatic cycle(input logic v, input logic [1:0] op, input logic [31:0] data);
    exp_t e;
    logic [31:0] ins;
    bit eb, hit, en, rdy, acc;
    ins = (pc == ebrkPc) ? EBREAK : ADDI;
    cmdIf.Cmd_valid = v; cmdIf.Cmd_op = op; cmdIf.Cmd_data = data;
    Pc = pc; Instruction = ins;
    eb  = (ins == EBREAK);
    hit = mBpEn && (pc[31:2] == mBpAddr) && !mSkip;
    en  = (mState == S_RUN && !hit && !eb) || (mState == S_STEP && !eb);
    rdy = (mState != S_STEP);
    acc = v && rdy;
    e.coreEn = en; e.state = mState; e.halted = (mState == S_HALT); e.cause = mCause;
    e.rdy = rdy; e.cyc = mCyc; e.ins = mIns;
    expQ.push_back(e);
    @(posedge Clk);
    if (mState != S_HALT) mCyc = mCyc + 1;
    if (en) mIns = mIns + 1;
    if (acc && op == OP_SETBP) begin mBpAddr = data[31:2]; mBpEn = data[0]; end
    if (mState == S_HALT) begin
      if (acc && op == OP_RUN) begin mState = S_RUN; mSkip = 1'b1; end
      else if (acc && op == OP_STEP) mState = S_STEP;
    end else if (mState == S_RUN) begin
      mSkip = 1'b0;
      if (eb)                        begin mState = S_HALT; mCause = 2'd3; end
      else if (hit)                  begin mState = S_HALT; mCause = 2'd2; end
      else if (acc && op == OP_HALT) begin mState = S_HALT; mCause = 2'd1; end
    end else begin
      mState = S_HALT;
      mCause = eb ? 2'd3 : 2'd1;
    end
    if (en) pc = pc + 4;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, OP_RUN, '0);
  endtask

  task automatic runUntilHalt(input int maxCyc);
    int n = 0;
    while (mState != S_HALT && n < maxCyc) begin
      cycle(1'b0, OP_RUN, '0);
      n++;
    end
  endtask

  initial begin
    cmdIf.Cmd_valid = 1'b0; cmdIf.Cmd_op = OP_RUN; cmdIf.Cmd_data = '0;
    pc = '0; ebrkPc = 32'hFFFF_FFFF;
    modelReset();
    #1;
    doReset();

    // RUN from PC 0, HALT accepted on the sixth running cycle
    cycle(1'b1, OP_RUN, '0);
    idle(5);
    cycle(1'b1, OP_HALT, '0);
    chk("halt_instrs", Instr_count, 32'd6);
    chk("halt_cycles", Cycle_count, 32'd6);
    chk("halt_cause",  32'(Halt_cause), 32'd1);

    // Breakpoint at 0x10, run from 0
    pc = '0;
    cycle(1'b1, OP_SETBP, 32'h0000_0011);
    cycle(1'b1, OP_RUN, '0);
    runUntilHalt(20);
    chk("bp_cause",  32'(Halt_cause), 32'd2);
    chk("bp_instrs", Instr_count, 32'd10);
    chk("bp_cycles", Cycle_count, 32'd11);

    // Resume on the breakpoint; move it to 0x20 while running
    cycle(1'b1, OP_RUN, '0);
    cycle(1'b1, OP_SETBP, 32'h0000_0021);
    runUntilHalt(20);
    chk("resume_instrs", Instr_count, 32'd14);
    chk("resume_cause",  32'(Halt_cause), 32'd2);

    // Three single steps from the breakpoint address (commands offered during STEP are refused)
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b1, OP_STEP, '0);
      cycle(1'b1, OP_RUN, '0);
      chk("step_instrs", Instr_count, 32'(14 + i));
      chk("step_cause",  32'(Halt_cause), 32'd1);
      chk("step_halted", 32'(Halted), 32'd1);
    end

    // EBREAK at 0x34, then a STEP onto it
    ebrkPc = 32'h34;
    cycle(1'b1, OP_RUN, '0);
    runUntilHalt(20);
    chk("ebrk_cause",  32'(Halt_cause), 32'd3);
    chk("ebrk_instrs", Instr_count, 32'd19);
    cycle(1'b1, OP_STEP, '0);
    idle(1);
    chk("ebrk_step_cause",  32'(Halt_cause), 32'd3);
    chk("ebrk_step_instrs", Instr_count, 32'd19);
    pc = pc + 4;

    // Reset while running with a breakpoint ahead; it must be forgotten
    cycle(1'b1, OP_SETBP, 32'h0000_0049);
    cycle(1'b1, OP_RUN, '0);
    idle(2);
    doReset();
    cycle(1'b1, OP_RUN, '0);
    idle(17);
    chk("wrap_cycles", 32'(cycW), 32'd1);
    chk("wrap_instrs", 32'(insW), 32'd1);
    chk("nobp_running", 32'(State), 32'(S_RUN));
    cycle(1'b1, OP_HALT, '0);

    // Random commands, PC moves and EBREAK placement
    for (int i = 0; i < 600; i++) begin
      logic        v;
      logic [1:0]  op;
      logic [31:0] data;
      if (mState == S_HALT && $urandom_range(0, 3) == 0) pc = 4 * $urandom_range(0, 63);
      if ($urandom_range(0, 15) == 0) ebrkPc = pc + 4 * $urandom_range(0, 6);
      if ($urandom_range(0, 31) == 0) ebrkPc = 32'hFFFF_FFFF;
      v    = ($urandom_range(0, 2) == 0);
      op   = 2'($urandom_range(0, 3));
      data = {pc[31:2] + 30'($urandom_range(0, 5)), 1'b0, 1'($urandom_range(0, 1))};
      cycle(v, op, data);
      if ($urandom_range(0, 199) == 0) doReset();
    end

    @(negedge Clk);
    #1;
    chk("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Run-control sequencer for the single-cycle RV32I core. It gates every architectural update of the core (PC load, register write, data-memory write) through one enable, Core_en. It accepts run/halt/single-step/breakpoint commands over a valid/ready port, stops on a PC breakpoint or an EBREAK instruction, and keeps cycle and retired-instruction counters. It sits between the host/debug interface and the processor top level. It observes the core's PC and fetched instruction.

## Interface
- CNT_W, 32: width of Cycle_count and Instr_count.
- Clk  input  1  sole clock; all state updates on its rising edge.
- Rst_n  input  1  reset; asynchronous, active-low.
- Cmd_valid  input  1  host command present.
- Cmd_ready  output  1  sequencer can accept a command this cycle.
- Cmd_op  input  2  00 RUN, 01 HALT, 10 STEP, 11 SET_BP.
- Cmd_data  input  32  SET_BP payload: [31:2] breakpoint word address, [0] breakpoint enable; ignored for other ops.
- Pc  input  32  current PC of the core.
- Instruction  input  32  instruction fetched at Pc.
- Core_en  output  1  1 = the core commits the instruction at Pc this cycle; the top level ANDs it into the PC load, RUWr and DMWr.
- State  output  2  00 HALTED, 01 RUNNING, 10 STEP.
- Halted  output  1  State == HALTED.
- Halt_cause  output  2  00 reset, 01 HALT command, 10 breakpoint, 11 EBREAK.
- Cycle_count  output  CNT_W  cycles spent outside HALTED.
- Instr_count  output  CNT_W  cycles with Core_en = 1.

## Operation
- A command is accepted on a rising edge where Cmd_valid and Cmd_ready are both 1.
- Cmd_ready = 1 in HALTED and RUNNING, and 0 in STEP.
- Internal registers:
  - Bp_addr[31:2] and Bp_en.
  - Skip: suppresses the breakpoint for the first instruction after a resume.
- Derived signals:
  - bp_hit = Bp_en and Pc[31:2] == Bp_addr and not Skip.
  - ebrk = (Instruction == 32'h00100073).
- Core_en (combinational):
  - RUNNING: 1 unless bp_hit or ebrk.
  - STEP: 1 unless ebrk. STEP ignores the breakpoint.
  - HALTED: 0.
- Transitions out of HALTED:
  - Accepted RUN goes to RUNNING and sets Skip.
  - Accepted STEP goes to STEP.
  - Accepted HALT is a no-op; Halt_cause is unchanged.
- Transitions out of RUNNING:
  - ebrk goes to HALTED with cause 11. ebrk has priority over bp_hit and over an accepted HALT.
  - Otherwise bp_hit goes to HALTED with cause 10.
  - Otherwise an accepted HALT goes to HALTED with cause 01. The instruction in the acceptance cycle still commits.
  - RUN and STEP accepted in RUNNING are no-ops.
- STEP always returns to HALTED after exactly one cycle:
  - cause 11 if ebrk, in which case nothing commits;
  - cause 01 otherwise, after one instruction commits.
- Skip clears after the first RUNNING cycle.
- SET_BP is accepted in any state except STEP. It loads Bp_addr and Bp_en on the edge and does not change state.
- An EBREAK is never skipped. The host must move PC or patch memory before resuming.
- Counters:
  - Cycle_count increments when State != HALTED.
  - Instr_count increments when Core_en = 1.
  - Both wrap modulo 2^CNT_W and clear only on reset.

## Timing
- Reset (Rst_n = 0, asynchronous) drives:
  - State HALTED, Halted 1, Halt_cause 00;
  - both counters 0;
  - Bp_en 0, Bp_addr 0, Skip 0;
  - Core_en 0, Cmd_ready 1.
- Reset released mid-run leaves the core halted. No command issued before reset survives.
- Command latency: accepted on edge N, new State visible after edge N, and Core_en reflects it in cycle N+1.
- Halt latency on breakpoint or EBREAK is zero: Core_en is low in the same cycle Pc matches, so the matching instruction does not commit.
- Core_en depends combinationally on State, Skip, Bp_*, Pc and Instruction. It has no path from Cmd_*.
- Counters update on the same edge as the state register; both use pre-edge State and Core_en.

## Test plan
- Reset, then RUN with the core executing ADDIs from PC 0 and HALT accepted at cycle 5:
  - Core_en is 1 for 6 cycles;
  - then Halted = 1 and Halt_cause = 01;
  - Instr_count = 6 and Cycle_count = 6.
- SET_BP with Cmd_data = 32'h0000_0011, then RUN from PC 0:
  - Core_en drops in the cycle Pc = 0x10;
  - Halt_cause = 10 and Instr_count = 4.
- Resume with RUN at Pc = 0x10: the instruction at 0x10 commits because Skip is set; the breakpoint re-arms at 0x14.
- STEP three times from HALTED:
  - Instr_count increments by exactly 1 each time;
  - Cmd_ready = 0 during each STEP cycle;
  - Halt_cause = 01 after each step.
- RUN into Instruction = 32'h00100073:
  - Core_en = 0 in that cycle and Halt_cause = 11;
  - a following STEP at the same Pc commits nothing and returns cause 11.
- Assert Rst_n = 0 for one cycle while RUNNING with a breakpoint set: all outputs return to reset values at once and Bp_en = 0. With CNT_W = 4, running 17 cycles gives Cycle_count = 1 (wrap).
